if_id_queue: RTL
================

# if_id_queue

Fetch-side decoupling queue between the PC/instruction ROM pair and the ID stage of the five-stage pipeline. Each PC advance counts as one issued fetch. The block pairs each issued PC with the instruction word the synchronous ROM returns one cycle later, and buffers up to DEPTH {pc, inst} entries. It presents the oldest entry to ID and back-pressures fetch through a stall request to the stall controller, so no fetch is lost or duplicated when ID stalls.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (`RST_ENABLE` = 1'b0).
- ce_i  input  1  PC chip enable; fetch is live only when 1.
- pc_i  input  32  current PC, presented to ROM this cycle.
- ctrl_stall_i  input  `STALL_BUS`  stall vector; bit 0 holds PC.
- inst_i  input  32  ROM read data for the PC issued in the previous cycle.
- id_stall_i  input  1  ID not accepting this cycle; must not depend combinationally on fetch_hold_o.
- flush_i  input  1  discard all buffered and in-flight fetches.
- id_pc_o  output  32  PC of head entry.
- id_inst_o  output  32  instruction of head entry.
- id_valid_o  output  1  head entry valid.
- fetch_hold_o  output  1  stall request to controller, ORed into ctrl_stall[0].

## Operation
- issue = ce_i & ~ctrl_stall_i[0]. PC advances exactly in issue cycles, so each PC is counted once. Non-issue cycles produce no entry, and repeated ROM reads of a held PC are ignored.
- inflight_q <= issue; pc_q <= pc_i. When inflight_q = 1, enqueue {pc_q, inst_i} at the end of that cycle.
- deq = id_valid_o & ~id_stall_i; head pointer advances.
- id_valid_o = (count ≠ 0). When count = 0: id_pc_o = 32'h0, id_inst_o = 32'h0 (NOP).
- fetch_hold_o = (count + inflight_q − deq ≥ DEPTH). The result is combinational from registered state plus deq.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. The entry enqueued in a cycle is never the one dequeued in that cycle; there is no bypass.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH+1) bits and never exceeds DEPTH. An enqueue that would overflow cannot occur under the hold rule; the bench checks this.
- Branch/delay slot: the fetch in flight when ID redirects the PC is the delay slot and is kept. No special handling.
- flush_i = 1 has priority over enqueue, dequeue and issue in that cycle. Next cycle: count = 0, pointers = 0, inflight_q = 0. Any ROM data returning in the following cycle is dropped.
- rst = 0: count, pointers, inflight_q, pc_q = 0. Outputs the next cycle: id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, fetch_hold_o = 0. Storage contents are don't-care.

## Timing
- Issue in cycle t → ROM data in t+1 → entry visible at ID in t+2. Minimum latency is 2 cycles.
- Throughput is one entry per cycle sustained when ID never stalls, with DEPTH = 2.
- When ID stalls, fetch_hold_o asserts in the same cycle the budget is exhausted. The controller raises ctrl_stall[0] combinationally, so no issue occurs that cycle.
- After a stall release (first cycle with deq = 1), fetch_hold_o drops in that cycle. Issue resumes and entries drain in FIFO order.
- Reset mid-operation: all in-flight and buffered fetches are lost. Behaviour matches power-on from the first cycle after rst returns to 1.

## Structure
- DEFINE.v carries `RST_ENABLE` (1'b0), `STALL_BUS`, `INST_ADDR_BUS`, `INST_DATA_BUS`, `ZERO_WORD`, `NOP_INST`. The block adds no new global constants.
- One sub-module, fetch_fifo, holds DEPTH × 64-bit register storage with head/tail pointers, count, push/pop/clear, and head read. if_id_queue keeps the issue tracking, hold computation and output muxing.

## Test plan
- Reset: hold rst = 0 for 2 cycles with ce_i = 1 → id_valid_o = 0, id_inst_o = 0, fetch_hold_o = 0. First issue appears at ID exactly 2 cycles after ce_i-qualified issue.
- Stream: PC from 0xBFC00000 stepping +4, inst_i = ~pc of prior cycle, no stalls → id_pc_o sequence 0xBFC00000, 0xBFC00004, … one per cycle, each paired with the correct inst, fetch_hold_o never 1.
- ID stall: id_stall_i = 1 for 4 cycles mid-stream with DEPTH = 2 → fetch_hold_o = 1 once count + inflight reaches 2, count never > 2. After release the next PCs arrive in order with no gaps or duplicates.
- External PC stall: ctrl_stall_i[0] = 1 for 3 cycles with PC held at 0xBFC00010 → exactly one entry with that PC is delivered.
- Flush: flush_i = 1 with queue full and inflight_q = 1 → id_valid_o = 0 next cycle, returning inst_i dropped. The first post-flush issue reaches ID 2 cycles after it is issued.
- Reset mid-stream: rst = 0 for one cycle with 2 entries buffered → all outputs at reset values next cycle, and no stale entry reappears.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants and the {pc, inst} entry type for the IF/ID decoupling queue.
package if_id_queue_pkg;

  localparam logic        RST_ENABLE  = 1'b0;
  localparam int unsigned STALL_W     = 6;
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;
  localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [INST_DATA_W-1:0] NOP_INST  = '0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_fetch_fifo.sv
// DEPTH-entry register FIFO of fetched {pc, inst} pairs with clear, push, pop and head read.
module fetch_fifo
  import if_id_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  fetch_entry_t      push_data_i,
  output fetch_entry_t      head_o,
  output logic [CNT_W-1:0]  count_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = push_data_i;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop_i) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_id_queue.sv
// Pairs each issued PC with the ROM word returned a cycle later, queues the pairs
// toward ID, and requests a fetch stall when the queue budget is exhausted.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [STALL_W-1:0]     ctrl_stall_i,
  input  logic [INST_DATA_W-1:0] inst_i,
  input  logic                   id_stall_i,
  input  logic                   flush_i,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_DATA_W-1:0] id_inst_o,
  output logic                   id_valid_o,
  output logic                   fetch_hold_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic                   inflight_q, inflight_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic                   issue, deq, push, pop;
  logic [CNT_W-1:0]       count;
  fetch_entry_t           head;
  fetch_entry_t           push_data;
  logic                   unused_stall;

  assign unused_stall = ^ctrl_stall_i[STALL_W-1:1];

  assign issue     = ce_i & ~ctrl_stall_i[0];
  assign deq       = id_valid_o & ~id_stall_i;
  assign push      = inflight_q & ~flush_i;
  assign pop       = deq & ~flush_i;
  assign push_data = '{pc: pc_q, inst: inst_i};

  always_comb begin
    inflight_d = flush_i ? 1'b0 : issue;
    pc_d       = pc_i;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (flush_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .head_o      (head),
    .count_o     (count)
  );

  // count + inflight - deq >= DEPTH, rearranged to stay unsigned.
  always_comb begin
    id_valid_o   = (count != '0);
    id_pc_o      = ZERO_WORD;
    id_inst_o    = NOP_INST;
    fetch_hold_o = (SUM_W'(count) + SUM_W'(inflight_q)) >= (SUM_W'(DEPTH) + SUM_W'(deq));
    if (id_valid_o) begin
      id_pc_o   = head.pc;
      id_inst_o = head.inst;
    end
  end

endmodule
